// File: rtl/bloco_controle_pkg.sv
// Shared definitions for the polynomial controller.
// - state_t : 3-bit binary state encoding
// - SEL0_*/SEL1_*/SEL2_* : datapath mux select codes
// - H_ADD/H_MUL : ULA operation codes
// - ctl_t : bundle of every controller output, one field per port
package bloco_controle_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_Q_MUL_AX = 3'd2,
    S_Q_ADD_B  = 3'd3,
    S_Q_MUL_X  = 3'd4,
    S_L_MUL_BX = 3'd5,
    S_ADD_C    = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  localparam logic [1:0] SEL0_ZERO = 2'b00;
  localparam logic [1:0] SEL0_A    = 2'b01;
  localparam logic [1:0] SEL0_B    = 2'b10;
  localparam logic [1:0] SEL0_C    = 2'b11;

  localparam logic [1:0] SEL1_MUX0 = 2'b00;
  localparam logic [1:0] SEL1_X    = 2'b01;
  localparam logic [1:0] SEL1_LS   = 2'b10;
  localparam logic [1:0] SEL1_LH   = 2'b11;

  localparam logic [1:0] SEL2_X    = 2'b00;
  localparam logic [1:0] SEL2_MUX0 = 2'b01;
  localparam logic [1:0] SEL2_LS   = 2'b10;
  localparam logic [1:0] SEL2_LH   = 2'b11;

  localparam logic H_ADD = 1'b0;
  localparam logic H_MUL = 1'b1;

  typedef struct packed {
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       lx;
    logic       ls;
    logic       lh;
    logic       h;
    logic       busy;
    logic       done;
  } ctl_t;

  // Output word of an idle controller; every state starts from this.
  localparam ctl_t CTL_IDLE = '{m0: SEL0_ZERO, m1: SEL1_MUX0, m2: SEL2_X,
                                lx: 1'b0, ls: 1'b0, lh: 1'b0, h: H_ADD,
                                busy: 1'b0, done: 1'b0};

endpackage

// File: rtl/bloco_controle_if.sv
// Handshake and datapath-control bundle of the polynomial controller.
// - master : requester side (drives start/mode, observes everything else)
// - slave  : controller side (samples start/mode, drives selects/loads/h/busy/done)
interface bloco_controle_if;
  logic       start;
  logic       mode;
  logic [1:0] M0;
  logic [1:0] M1;
  logic [1:0] M2;
  logic       LX;
  logic       LS;
  logic       LH;
  logic       h;
  logic       busy;
  logic       done;

  modport master (output start, mode,
                  input  M0, M1, M2, LX, LS, LH, h, busy, done);
  modport slave  (input  start, mode,
                  output M0, M1, M2, LX, LS, LH, h, busy, done);
endinterface

// File: rtl/bloco_controle.sv
// Control unit for the Horner polynomial datapath.
// Evaluates S = A*X^2 + B*X + C (mode 0) or S = B*X + C (mode 1),
// one ULA operation per state.
// Ports:
// - clk   : rising-edge clock
// - rst_n : asynchronous active-low reset
// - bus   : slave side of bloco_controle_if (start/mode in;
//           M0/M1/M2/LX/LS/LH/h/busy/done out)
// All outputs are Moore-decoded from state_q, so they follow reset immediately.
module bloco_controle
  import bloco_controle_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  bloco_controle_if.slave bus
);

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  ctl_t   ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Next state. mode is latched only on an accepted start so a requester
  // toggling it mid-run cannot change the sequence.
  always_comb begin
    state_d = S_IDLE;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          mode_d  = bus.mode;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:     state_d = mode_q ? S_L_MUL_BX : S_Q_MUL_AX;
      S_Q_MUL_AX: state_d = S_Q_ADD_B;
      S_Q_ADD_B:  state_d = S_Q_MUL_X;
      S_Q_MUL_X:  state_d = S_ADD_C;
      S_L_MUL_BX: state_d = S_ADD_C;
      S_ADD_C:    state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ctl = CTL_IDLE;
    case (state_q)
      S_LOAD: begin
        ctl.lx   = 1'b1;
        ctl.busy = 1'b1;
      end
      S_Q_MUL_AX: begin  // LS <- A*X
        ctl.m0 = SEL0_A;  ctl.m1 = SEL1_MUX0; ctl.m2 = SEL2_X;
        ctl.h  = H_MUL;   ctl.ls = 1'b1;      ctl.busy = 1'b1;
      end
      S_Q_ADD_B: begin   // LS <- LS + B
        ctl.m0 = SEL0_B;  ctl.m1 = SEL1_MUX0; ctl.m2 = SEL2_LS;
        ctl.h  = H_ADD;   ctl.ls = 1'b1;      ctl.busy = 1'b1;
      end
      S_Q_MUL_X: begin   // LS <- LS * X
        ctl.m1 = SEL1_LS; ctl.m2 = SEL2_X;
        ctl.h  = H_MUL;   ctl.ls = 1'b1;      ctl.busy = 1'b1;
      end
      S_L_MUL_BX: begin  // LS <- B*X
        ctl.m0 = SEL0_B;  ctl.m1 = SEL1_MUX0; ctl.m2 = SEL2_X;
        ctl.h  = H_MUL;   ctl.ls = 1'b1;      ctl.busy = 1'b1;
      end
      S_ADD_C: begin     // LS <- LS + C
        ctl.m0 = SEL0_C;  ctl.m1 = SEL1_MUX0; ctl.m2 = SEL2_LS;
        ctl.h  = H_ADD;   ctl.ls = 1'b1;      ctl.busy = 1'b1;
      end
      S_DONE:  ctl.done = 1'b1;
      default: ctl = CTL_IDLE;
    endcase
  end

  assign bus.M0   = ctl.m0;
  assign bus.M1   = ctl.m1;
  assign bus.M2   = ctl.m2;
  assign bus.LX   = ctl.lx;
  assign bus.LS   = ctl.ls;
  assign bus.LH   = ctl.lh;
  assign bus.h    = ctl.h;
  assign bus.busy = ctl.busy;
  assign bus.done = ctl.done;

endmodule

// File: tb/tb_bloco_controle.sv
// Bench for bloco_controle: per-cycle output vectors from a table, a
// behavioural model of the datapath to produce resultado, plus hand-written
// sequences for async reset mid-run and start held high.
module tb_bloco_controle;

  // Expected output words {M0,M1,M2,LX,LS,LH,h,busy,done}
  localparam logic [11:0] O_IDLE = 12'b00_00_00_0_0_0_0_0_0;
  localparam logic [11:0] O_LOAD = 12'b00_00_00_1_0_0_0_1_0;
  localparam logic [11:0] O_QAX  = 12'b01_00_00_0_1_0_1_1_0;
  localparam logic [11:0] O_QB   = 12'b10_00_10_0_1_0_0_1_0;
  localparam logic [11:0] O_QX   = 12'b00_10_00_0_1_0_1_1_0;
  localparam logic [11:0] O_LBX  = 12'b10_00_00_0_1_0_1_1_0;
  localparam logic [11:0] O_AC   = 12'b11_00_10_0_1_0_0_1_0;
  localparam logic [11:0] O_DONE = 12'b00_00_00_0_0_0_0_0_1;

  typedef struct {
    logic        st;
    logic        md;
    logic [15:0] a, b, c;
    logic [7:0]  x;
    logic [11:0] exp;
    logic        chk_res;
    logic [15:0] res;
  } vec_t;

  logic clk, rst_n;
  bloco_controle_if bus();

  bloco_controle dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model
  logic [15:0] a_in, b_in, c_in;
  logic [7:0]  x_in;
  logic [15:0] x_r, ls_r, lh_r, mux0, mux1, mux2, ula;

  always_comb begin
    case (bus.M0)
      2'b00:   mux0 = 16'h0000;
      2'b01:   mux0 = a_in;
      2'b10:   mux0 = b_in;
      default: mux0 = c_in;
    endcase
    case (bus.M1)
      2'b00:   mux1 = mux0;
      2'b01:   mux1 = x_r;
      2'b10:   mux1 = ls_r;
      default: mux1 = lh_r;
    endcase
    case (bus.M2)
      2'b00:   mux2 = x_r;
      2'b01:   mux2 = mux0;
      2'b10:   mux2 = ls_r;
      default: mux2 = lh_r;
    endcase
    ula = bus.h ? 16'(mux1 * mux2) : 16'(mux1 + mux2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r  <= 16'h0000;
      ls_r <= 16'h0000;
      lh_r <= 16'h0000;
    end else begin
      if (bus.LX) x_r  <= {8'h00, x_in};
      if (bus.LS) ls_r <= ula;
      if (bus.LH) lh_r <= ula;
    end
  end

  int checks = 0;
  int errors = 0;
  vec_t tv[$];

  function automatic logic [11:0] outs();
    return {bus.M0, bus.M1, bus.M2, bus.LX, bus.LS, bus.LH, bus.h, bus.busy, bus.done};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic add(input logic st, input logic md, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] c, input logic [7:0] x,
                     input logic [11:0] exp, input logic cr, input logic [15:0] res);
    vec_t v;
    v.st = st; v.md = md; v.a = a; v.b = b; v.c = c; v.x = x;
    v.exp = exp; v.chk_res = cr; v.res = res;
    tv.push_back(v);
  endtask

  task automatic set_data(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [7:0] x);
    a_in = a; b_in = b; c_in = c; x_in = x;
  endtask

  initial begin
    // quadratic: 2*9 + 5*3 + 7 = 40
    add(1,0, 16'd2,16'd5,16'd7,8'd3, O_LOAD, 0, 16'd0);
    add(0,0, 16'd2,16'd5,16'd7,8'd3, O_QAX,  0, 16'd0);
    add(0,0, 16'd2,16'd5,16'd7,8'd3, O_QB,   0, 16'd0);
    add(0,0, 16'd2,16'd5,16'd7,8'd3, O_QX,   0, 16'd0);
    add(0,0, 16'd2,16'd5,16'd7,8'd3, O_AC,   0, 16'd0);
    add(0,0, 16'd2,16'd5,16'd7,8'd3, O_DONE, 1, 16'd40);
    add(0,0, 16'd2,16'd5,16'd7,8'd3, O_IDLE, 1, 16'd40);
    // linear: 5*3 + 7 = 22, A is don't care
    add(1,1, 16'hFFFF,16'd5,16'd7,8'd3, O_LOAD, 0, 16'd0);
    add(0,1, 16'hFFFF,16'd5,16'd7,8'd3, O_LBX,  0, 16'd0);
    add(0,1, 16'hFFFF,16'd5,16'd7,8'd3, O_AC,   0, 16'd0);
    add(0,1, 16'hFFFF,16'd5,16'd7,8'd3, O_DONE, 1, 16'd22);
    add(0,1, 16'hFFFF,16'd5,16'd7,8'd3, O_IDLE, 1, 16'd22);
    // quadratic with start re-pulsed and mode toggled while busy, start in DONE
    add(1,0, 16'd2,16'd5,16'd7,8'd3, O_LOAD, 0, 16'd0);
    add(1,1, 16'd2,16'd5,16'd7,8'd3, O_QAX,  0, 16'd0);
    add(0,1, 16'd2,16'd5,16'd7,8'd3, O_QB,   0, 16'd0);
    add(1,1, 16'd2,16'd5,16'd7,8'd3, O_QX,   0, 16'd0);
    add(1,0, 16'd2,16'd5,16'd7,8'd3, O_AC,   0, 16'd0);
    add(0,1, 16'd2,16'd5,16'd7,8'd3, O_DONE, 1, 16'd40);
    add(1,0, 16'd2,16'd5,16'd7,8'd3, O_IDLE, 1, 16'd40);
    add(0,0, 16'd2,16'd5,16'd7,8'd3, O_IDLE, 1, 16'd40);
    // wrap-around: (2*255)*255 mod 2^16 = 0xFC02
    add(1,0, 16'd2,16'd0,16'd0,8'd255, O_LOAD, 0, 16'd0);
    add(0,0, 16'd2,16'd0,16'd0,8'd255, O_QAX,  0, 16'd0);
    add(0,0, 16'd2,16'd0,16'd0,8'd255, O_QB,   0, 16'd0);
    add(0,0, 16'd2,16'd0,16'd0,8'd255, O_QX,   0, 16'd0);
    add(0,0, 16'd2,16'd0,16'd0,8'd255, O_AC,   0, 16'd0);
    add(0,0, 16'd2,16'd0,16'd0,8'd255, O_DONE, 1, 16'hFC02);
    add(0,0, 16'd2,16'd0,16'd0,8'd255, O_IDLE, 1, 16'hFC02);

    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    set_data(16'd0, 16'd0, 16'd0, 8'd0);
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", {4'h0, outs()}, {4'h0, O_IDLE});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_after_reset", {4'h0, outs()}, {4'h0, O_IDLE});

    // table-driven vectors: inputs for edge i, outputs observed after edge i
    for (int i = 0; i < tv.size(); i++) begin
      bus.start = tv[i].st;
      bus.mode  = tv[i].md;
      set_data(tv[i].a, tv[i].b, tv[i].c, tv[i].x);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d_outs", i), {4'h0, outs()}, {4'h0, tv[i].exp});
      if (tv[i].chk_res) chk($sformatf("row%0d_res", i), ls_r, tv[i].res);
    end

    // start held high: done pulses in cycles 6, 13, 20, one cycle wide each
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    set_data(16'd2, 16'd5, 16'd7, 8'd3);
    for (int k = 0; k < 21; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("held_done_c%0d", k + 1), {15'h0, bus.done},
          {15'h0, (k == 5 || k == 12 || k == 19)});
      if (bus.done) chk($sformatf("held_res_c%0d", k + 1), ls_r, 16'd40);
    end
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("held_back_idle", {4'h0, outs()}, {4'h0, O_IDLE});

    // async reset while in Q_ADD_B, then a fresh run
    bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("mid_in_qaddb", {4'h0, outs()}, {4'h0, O_QB});
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_outputs", {4'h0, outs()}, {4'h0, O_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_reset_stays_idle", {4'h0, outs()}, {4'h0, O_IDLE});
    bus.start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("post_reset_done", {4'h0, outs()}, {4'h0, O_DONE});
    chk("post_reset_res", ls_r, 16'd40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
